// File: rtl/mdu_e_pkg.sv
// mdu_e_pkg: shared MDU operation codes for the E-stage multiply/divide unit
// and the controller that drives it.
// Contents: mdu_* opcode constants plus a helper that identifies launchable ops.
package mdu_e_pkg;

  localparam logic [2:0] mdu_none  = 3'd0;
  localparam logic [2:0] mdu_mult  = 3'd1;
  localparam logic [2:0] mdu_multu = 3'd2;
  localparam logic [2:0] mdu_div   = 3'd3;
  localparam logic [2:0] mdu_divu  = 3'd4;
  localparam logic [2:0] mdu_mthi  = 3'd5;
  localparam logic [2:0] mdu_mtlo  = 3'd6;

  // Only the four arithmetic ops occupy the unit; mthi/mtlo are single-edge writes.
  function automatic logic is_launch_op(input logic [2:0] op);
    return (op == mdu_mult) || (op == mdu_multu) ||
           (op == mdu_div)  || (op == mdu_divu);
  endfunction

endpackage

// File: rtl/mdu_e.sv
// mdu_e: multi-cycle multiply/divide unit holding the HI/LO register pair.
// Ports: clk, reset (sync, active-high), Start/MDUop/SrcA/SrcB launch an op,
//   Req squashes this cycle's launch or mthi/mtlo, Busy feeds the hazard unit,
//   HI/LO are the architectural registers (updated only at commit).
module mdu_e
  import mdu_e_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       MDUop,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Req,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
  // Cleared for divide-by-zero so the commit edge leaves HI/LO untouched.
  logic             wr_q, wr_d;

  logic               idle;
  logic               launch;
  logic               is_signed;
  logic               is_mult;
  logic               div_zero;
  logic [2*WIDTH-1:0] ext_a, ext_b, divisor;

  assign idle      = (cnt_q == '0);
  assign launch    = Start & ~Req & idle & is_launch_op(MDUop);
  assign is_signed = (MDUop == mdu_mult) || (MDUop == mdu_div);
  assign is_mult   = (MDUop == mdu_mult) || (MDUop == mdu_multu);
  assign div_zero  = (SrcB == '0);

  // Double-width operands: the low 2*WIDTH bits of the product are exact for
  // both signednesses, and the signed quotient of MIN / -1 fits without overflow.
  assign ext_a   = is_signed ? {{WIDTH{SrcA[WIDTH-1]}}, SrcA} : {{WIDTH{1'b0}}, SrcA};
  assign ext_b   = is_signed ? {{WIDTH{SrcB[WIDTH-1]}}, SrcB} : {{WIDTH{1'b0}}, SrcB};
  // Dummy divisor keeps the operator defined; its result is never committed.
  assign divisor = div_zero ? {{(2*WIDTH-1){1'b0}}, 1'b1} : ext_b;

  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    wr_d     = wr_q;

    if (launch) begin
      if (is_mult) begin
        cnt_d                = CW'(MULT_CYCLES);
        {hi_tmp_d, lo_tmp_d} = ext_a * ext_b;
        wr_d                 = 1'b1;
      end else begin
        cnt_d = CW'(DIV_CYCLES);
        if (is_signed) begin
          lo_tmp_d = WIDTH'($signed(ext_a) / $signed(divisor));
          hi_tmp_d = WIDTH'($signed(ext_a) % $signed(divisor));
        end else begin
          lo_tmp_d = WIDTH'(ext_a / divisor);
          hi_tmp_d = WIDTH'(ext_a % divisor);
        end
        wr_d = ~div_zero;
      end
    end else if (!idle) begin
      // Req in flight does not cancel; the op always runs to commit.
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1) && wr_q) begin
        hi_d = hi_tmp_q;
        lo_d = lo_tmp_q;
      end
    end else if (!Start && !Req) begin
      if (MDUop == mdu_mthi) hi_d = SrcA;
      if (MDUop == mdu_mtlo) lo_d = SrcA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
      wr_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      wr_q     <= wr_d;
    end
  end

  // High in the launch cycle too, so a dependent instruction stalls immediately.
  assign Busy = Start | ~idle;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
